// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Latency: n/a (declarations and a combinational helper function only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int RR_MAX      = 8;   // widest requester vector next_rr handles

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        ACK
    } arb_state_t;

    // Round-robin pick: first set bit of req searching upward from last+1,
    // wrapping modulo n. n is a constant at every call site, so the modulo
    // folds away in synthesis. Returns last when no bit is set.
    function automatic logic [2:0] next_rr(input logic [RR_MAX-1:0] req,
                                           input logic [2:0]        last,
                                           input int unsigned       n);
        logic [2:0] sel;
        logic       found;
        logic [2:0] idx;
        sel   = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX; i++) begin
            idx = 3'((32'(last) + i) % n);
            if (!found && (i <= n) && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Single-bit multi-flop synchroniser for transmitter status into i_clk.
// Latency: SYNC_STAGES i_clk cycles from i_d to o_q.
// Backpressure: none; samples every cycle.
// Ports: i_clk clock, i_rst sync active-high clear, i_d async input, o_q synced output.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// Latency: grant + start on the first edge after a request in IDLE; ack one cycle after tx completion is seen.
// Backpressure: requesters hold i_req until o_ack; START holds start/data until the synced busy is seen.
// Ports: i_clk/i_arb_rst (sync, active-high); i_req/i_req_data requester side; o_ack/o_grant_id/o_arb_busy/
//        o_arb_timeout status; o_start_bit/o_tx_data and i_tx_busy/i_tx_done (tx clock domain) to uart_tx.
// Optional: define UART_ARB_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES in START/WAIT.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         i_clk,
    input  logic                         i_arb_rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*UART_DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]           o_ack,
    output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
    output logic                         o_arb_busy,
    output logic                         o_arb_timeout,
    output logic                         o_start_bit,
    output logic [UART_DATA_W-1:0]       o_tx_data,
    input  logic                         i_tx_busy,
    input  logic                         i_tx_done
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   start_q, start_d;
    logic [RR_MAX-1:0]      req_pad;
    logic [ID_W-1:0]        win;
    logic                   busy_s;
    logic                   done_s;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_busy (
        .i_clk (i_clk),
        .i_rst (i_arb_rst),
        .i_d   (i_tx_busy),
        .o_q   (busy_s)
    );

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
        .i_clk (i_clk),
        .i_rst (i_arb_rst),
        .i_d   (i_tx_done),
        .o_q   (done_s)
    );

    assign req_pad = RR_MAX'(i_req);

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q, tmo_d;
    logic        tmo_hit;

    // The count reaches TIMEOUT_CYCLES on the edge that would take it there,
    // so the abort edge is exactly TIMEOUT_CYCLES edges after entering START.
    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_arb_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            data_q  <= '0;
            start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            start_q <= start_d;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        start_d = start_q;
        win     = ID_W'(next_rr(req_pad, 3'(last_q), NUM_REQ));
`ifdef UART_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    grant_d = win;
                    data_d  = i_req_data[32'(win)*UART_DATA_W +: UART_DATA_W];
                    start_d = 1'b1;
                    state_d = START;
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            START: begin
`ifdef UART_ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                // Level handshake: hold start until the transmitter's busy has
                // crossed into this domain, whatever the clock ratio.
                if (busy_s) begin
                    start_d = 1'b0;
                    state_d = WAIT;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    start_d = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ACK;
                end
`endif
            end
            WAIT: begin
`ifdef UART_ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                // A real completion in the same cycle as the deadline is
                // reported as a completion, not an abort.
                if (!busy_s || done_s) begin
                    state_d = ACK;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = ACK;
                end
`endif
            end
            ACK: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_ack = '0;
        if (state_q == ACK) begin
            o_ack[grant_q] = 1'b1;
        end
    end

    assign o_grant_id  = grant_q;
    assign o_arb_busy  = (state_q != IDLE);
    assign o_start_bit = start_q;
    assign o_tx_data   = data_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign o_arb_timeout = tmo_q;
`else
    assign o_arb_timeout = 1'b0;
`endif

endmodule
